// File: rtl/mux41_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux41_arb_pkg
// Description : Shared constants, state encoding and helpers for the
//               mux41 round-robin arbiter.
//               NUM_REQ - number of requesters (mux41 data inputs)
//               SEL_W   - width of the mux41 select
//               state_e - arbiter FSM state (IDLE / OWN)
//               onehot  - index -> one-hot grant vector
// Revision    : 1.0 - initial release
// ============================================================================
package mux41_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    // Explicit 1-bit encoding so the state register is legacy-compatible.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_e;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] index);
        logic [NUM_REQ-1:0] result;
        result        = '0;
        result[index] = 1'b1;
        return result;
    endfunction

endpackage : mux41_arb_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Returns the first asserted
//               request found searching ptr, ptr+1, ... modulo NUM_REQ.
// Ports       : req [3:0] - request vector
//               ptr [1:0] - search start position
//               idx [1:0] - index of the winning request (ptr when none)
//               any       - at least one request asserted
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import mux41_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [SEL_W-1:0]   idx,
    output logic               any
);

    logic [SEL_W-1:0] cand;

    // Scan from the farthest position back towards ptr, so the candidate
    // closest to ptr is the last one written and therefore wins.
    always_comb begin
        idx  = ptr;
        cand = ptr;
        any  = |req;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ptr + SEL_W'(k);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/mux41_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux41_rr_arbiter
// Description : Round-robin arbiter driving the select of a 4:1 mux (mux41).
//               Requester i owns mux input Ii. The owner keeps the grant
//               while it requests, for at most MAX_HOLD consecutive cycles,
//               then ownership rotates to the next requester.
// Parameters  : MAX_HOLD - max consecutive grant cycles per owner (1..255)
//               CNT_W    - hold counter width, 2**CNT_W > MAX_HOLD
// Ports       : clk    - system clock, rising edge
//               rst_n  - asynchronous active-low reset
//               req    - request per mux input
//               lock   - (MUX41_ARB_LOCK_EN only) suppress the hold timeout
//               grant  - registered one-hot grant, zero when idle
//               sel    - registered mux select (index of the owner)
//               active - a grant is held, sel is meaningful
// Options     : MUX41_ARB_LOCK_EN - adds the lock input
// Revision    : 1.0 - initial release
// ============================================================================
module mux41_rr_arbiter
    import mux41_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
`ifdef MUX41_ARB_LOCK_EN
    input  logic               lock,
`endif
    output logic [NUM_REQ-1:0] grant,
    output logic [SEL_W-1:0]   sel,
    output logic               active
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_e             state_q,    state_d;
    logic [SEL_W-1:0]   ptr_q,      ptr_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [NUM_REQ-1:0] grant_q,    grant_d;
    logic [SEL_W-1:0]   sel_q,      sel_d;
    logic               active_q,   active_d;

    logic [SEL_W-1:0]   pick_ptr;
    logic [SEL_W-1:0]   pick_idx;
    logic               pick_any;
    logic               owner_req;
    logic               at_limit;
    logic               lock_hold;
    logic               do_release;

`ifdef MUX41_ARB_LOCK_EN
    assign lock_hold = lock;
`else
    assign lock_hold = 1'b0;
`endif

    // sel_q always names the current owner while in OWN.
    assign owner_req  = req[sel_q];
    assign at_limit   = (hold_cnt_q == HOLD_LAST);
    // Owner drop and timeout in the same cycle collapse into one release.
    assign do_release = !owner_req || (at_limit && !lock_hold);

    // On release the search must already start after the owner, so the
    // picker is fed the rotated pointer in OWN; in IDLE it uses ptr_q.
    assign pick_ptr = (state_q == OWN) ? (sel_q + SEL_W'(1)) : ptr_q;

    rr_pick u_rr_pick (
        .req (req),
        .ptr (pick_ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        grant_d    = grant_q;
        sel_d      = sel_q;
        active_d   = active_q;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d    = OWN;
                    grant_d    = onehot(pick_idx);
                    sel_d      = pick_idx;
                    active_d   = 1'b1;
                    hold_cnt_d = '0;
                end
            end

            OWN: begin
                if (do_release) begin
                    ptr_d      = sel_q + SEL_W'(1);
                    hold_cnt_d = '0;
                    if (pick_any) begin
                        // Direct hand-over, no idle cycle between owners.
                        grant_d  = onehot(pick_idx);
                        sel_d    = pick_idx;
                        active_d = 1'b1;
                    end else begin
                        // sel keeps the last owner to avoid mux toggling.
                        state_d  = IDLE;
                        grant_d  = '0;
                        active_d = 1'b0;
                    end
                end else if (!at_limit) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
                // at_limit without release only happens under lock:
                // the counter saturates at HOLD_LAST.
            end

            default: begin
                state_d  = IDLE;
                grant_d  = '0;
                active_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            grant_q    <= '0;
            sel_q      <= '0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            grant_q    <= grant_d;
            sel_q      <= sel_d;
            active_q   <= active_d;
        end
    end

    assign grant  = grant_q;
    assign sel    = sel_q;
    assign active = active_q;

endmodule : mux41_rr_arbiter
`default_nettype wire
